divider_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle 32-bit unsigned divider between several requesters in the PID motor-control path, such as the per-wheel PID channels and the speed-scaling logic. It accepts divide requests, issues one start pulse to the divider per grant, waits for the divider's valid strobe and routes quotient and remainder back to the granted requester. Divide-by-zero is trapped without touching the divider. A watchdog frees the divider if it never responds.

---
 rtl/divider_arbiter.sv | 163 ++++++++++++++++
 tb/tb_divider_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one multi-cycle 32-bit unsigned
// divider between NREQ requesters, with divide-by-zero trap and watchdog.
//
// Handshake: a requester holds iReq[k] with stable operands until the
// one-cycle oAck[k] pulse, at which edge iA/iB are captured. Exactly one
// oDone[k] pulse follows, carrying oQ/oR and the flags. On the divider side
// oDivEn is a one-cycle start pulse with oDivA/oDivB held stable until the
// divider answers with a single-cycle iDivValida, or the watchdog fires.
module divider_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 iClk100M,
    input  logic                 iRstN,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ*32-1:0]   iA,
    input  logic [NREQ*32-1:0]   iB,
    output logic [NREQ-1:0]      oAck,
    output logic [NREQ-1:0]      oDone,
    output logic [31:0]          oQ,
    output logic [31:0]          oR,
    output logic                 oDivZero,
    output logic                 oTimeout,
    output logic                 oBusy,
    output logic [31:0]          oDivA,
    output logic [31:0]          oDivB,
    output logic                 oDivEn,
    input  logic [31:0]          iDivS,
    input  logic [31:0]          iDivC,
    input  logic                 iDivValida,
    output logic                 dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic            found;
    logic [PW-1:0]   gsel;
    logic [31:0]     sel_a, sel_b;

    logic [NREQ-1:0] ack_nxt, done_nxt;
    logic [31:0]     q_nxt, r_nxt, diva_nxt, divb_nxt;
    logic            dz_nxt, to_nxt, busy_nxt, en_nxt;

    assign dbg_state = (state == S_WAIT);

    // Round-robin search: first requesting index at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && iReq[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                gsel  = PW'((int'(ptr) + i) % NREQ);
            end
        end
        sel_a = iA[32*int'(gsel) +: 32];
        sel_b = iB[32*int'(gsel) +: 32];
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        done_nxt  = '0;
        q_nxt     = oQ;
        r_nxt     = oR;
        dz_nxt    = 1'b0;
        to_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        en_nxt    = 1'b0;
        diva_nxt  = oDivA;
        divb_nxt  = oDivB;
        case (state)
            S_IDLE: begin
                if (found) begin
                    ack_nxt   = NREQ'(1) << gsel;
                    ptr_nxt   = PW'((int'(gsel) + 1) % NREQ);
                    owner_nxt = gsel;
                    if (sel_b != 32'd0) begin
                        diva_nxt  = sel_a;
                        divb_nxt  = sel_b;
                        en_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_WAIT;
                    end else begin
                        q_nxt    = 32'hFFFF_FFFF;
                        r_nxt    = sel_a;
                        done_nxt = NREQ'(1) << gsel;
                        dz_nxt   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Busy rises the cycle after the start pulse so the two never overlap.
                busy_nxt = 1'b1;
                if (iDivValida) begin
                    q_nxt     = iDivS;
                    r_nxt     = iDivC;
                    done_nxt  = NREQ'(1) << owner;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    q_nxt     = 32'd0;
                    r_nxt     = 32'd0;
                    done_nxt  = NREQ'(1) << owner;
                    to_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge iClk100M or negedge iRstN) begin
        if (!iRstN) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            oAck     <= '0;
            oDone    <= '0;
            oQ       <= '0;
            oR       <= '0;
            oDivZero <= 1'b0;
            oTimeout <= 1'b0;
            oBusy    <= 1'b0;
            oDivEn   <= 1'b0;
            oDivA    <= '0;
            oDivB    <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            cnt      <= cnt_nxt;
            oAck     <= ack_nxt;
            oDone    <= done_nxt;
            oQ       <= q_nxt;
            oR       <= r_nxt;
            oDivZero <= dz_nxt;
            oTimeout <= to_nxt;
            oBusy    <= busy_nxt;
            oDivEn   <= en_nxt;
            oDivA    <= diva_nxt;
            oDivB    <= divb_nxt;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter with a behavioural divider model.
module tb_divider_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [127:0]     a_bus, b_bus;
    logic [NREQ-1:0]  ack, done;
    logic [31:0]      q, r, diva, divb, divs, divc;
    logic             dz, to, busy, diven, divvalid, dbg;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           ptr = 0;
    logic [31:0]  op_a [NREQ];
    logic [31:0]  op_b [NREQ];
    logic [65:0]  exp_q [$];

    // divider model
    int           lat = 34;
    bit           never_valid = 1'b0;
    bit           stray = 1'b0;
    int           dcnt = 0;
    logic [31:0]  rq = '0, rr = '0;

    divider_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .iClk100M(clk), .iRstN(rst_n), .iReq(req), .iA(a_bus), .iB(b_bus),
        .oAck(ack), .oDone(done), .oQ(q), .oR(r), .oDivZero(dz), .oTimeout(to),
        .oBusy(busy), .oDivA(diva), .oDivB(divb), .oDivEn(diven),
        .iDivS(divs), .iDivC(divc), .iDivValida(divvalid), .dbg_state(dbg)
    );

    always #5 clk = ~clk;

    // external divider: result valid L cycles after the start pulse is sampled
    always @(posedge clk) begin
        if (diven) begin
            dcnt <= lat;
            rq   <= (divb != 0) ? diva / divb : 32'd0;
            rr   <= (divb != 0) ? diva % divb : 32'd0;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign divs = rq;
    assign divc = rr;
    assign divvalid = stray | (!never_valid && dcnt == 1);

    // per-cycle protocol invariants
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((diven && busy) || !$onehot0(ack) || !$onehot0(done)) begin
                errors++;
                $display("FAIL protocol: en=%b busy=%b ack=%b done=%b required en&busy=0 and one-hot-or-zero ack/done",
                         diven, busy, ack, done);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    function automatic int pick(logic [NREQ-1:0] rv);
        for (int i = 0; i < NREQ; i++)
            if (rv[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [65:0] expect_entry(int g, logic [31:0] a, logic [31:0] b);
        if (b == 0) return {2'(g), 32'hFFFF_FFFF, a};
        return {2'(g), a / b, a % b};
    endfunction

    task automatic set_ops(int k, logic [31:0] a, logic [31:0] b);
        op_a[k] = a;
        op_b[k] = b;
        a_bus[32*k +: 32] = a;
        b_bus[32*k +: 32] = b;
    endtask

    task automatic rand_ops(int k);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : ($urandom | 32'd1);
        set_ops(k, a, b);
    endtask

    task automatic wait_ack(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack != 0) begin n = i; return; end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done != 0) begin n = i; return; end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
    endtask

    task automatic check_result(string name, int n, int exp_n);
        logic [65:0] e;
        e = exp_q.pop_front();
        checks++;
        if (n !== exp_n) begin errors++; $display("FAIL %s_latency: got %0d required %0d", name, n, exp_n); end
        checks++;
        if (done !== (NREQ'(1) << e[65:64])) begin errors++; $display("FAIL %s_done: got %b required bit %0d", name, done, e[65:64]); end
        checks++;
        if (q !== e[63:32] || r !== e[31:0]) begin
            errors++; $display("FAIL %s_qr: got q=%h r=%h required q=%h r=%h", name, q, r, e[63:32], e[31:0]);
        end
        checks++;
        if (to !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL %s_flags: got to=%b dz=%b required 0 0", name, to, dz); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, done, q, r, dz, to, busy, diva, divb, diven, dbg} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ack=%b done=%b q=%h r=%h busy=%b en=%b required all 0", ack, done, q, r, busy, diven);
        end
        rst_n = 1'b1;
        ptr = 0;
    endtask

    task automatic test_single();
        int n;
        lat = 34;
        set_ops(0, 32'd100, 32'd7);
        req = 4'b0001;
        wait_ack(n);
        checks++;
        if (n !== 1 || ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got n=%0d ack=%b required 1 0001", n, ack); end
        checks++;
        if (diven !== 1'b1 || diva !== 32'd100 || divb !== 32'd7 || busy !== 1'b0) begin
            errors++; $display("FAIL single_start: got en=%b a=%0d b=%0d busy=%b required 1 100 7 0", diven, diva, divb, busy);
        end
        req = 4'b0000;
        ptr = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || diven !== 1'b0) begin errors++; $display("FAIL single_busy: got busy=%b en=%b required 1 0", busy, diven); end
        wait_done(n);
        exp_q.push_back({2'd0, 32'd14, 32'd2});
        check_result("single", n + 1, 35);
    endtask

    task automatic test_round_robin();
        int n, g, cur_lat;
        int grants [NREQ];
        pulse_reset();
        for (int k = 0; k < NREQ; k++) begin rand_ops(k); grants[k] = 0; end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            cur_lat = $urandom_range(1, 20);
            lat = cur_lat;
            g = pick(req);
            wait_ack(n);
            checks++;
            if (n !== 1 || ack !== (NREQ'(1) << g)) begin
                errors++; $display("FAIL rr_grant%0d: got n=%0d ack=%b required 1 bit %0d", t, n, ack, g);
            end
            for (int j = 0; j < NREQ; j++) if (ack[j]) grants[j]++;
            if (t == 3) begin
                checks++;
                if (grants[0] != 1 || grants[1] != 1 || grants[2] != 1 || grants[3] != 1) begin
                    errors++; $display("FAIL rr_fairness: got %0d %0d %0d %0d required 1 1 1 1", grants[0], grants[1], grants[2], grants[3]);
                end
            end
            exp_q.push_back(expect_entry(g, op_a[g], op_b[g]));
            ptr = (g + 1) % NREQ;
            rand_ops(g);
            if (t == 4) req = 4'b0000;
            wait_done(n);
            check_result("rr", n, cur_lat + 1);
        end
    endtask

    task automatic test_div_zero();
        int n, g, bad;
        set_ops(2, 32'h1234, 32'd0);
        req = 4'b0100;
        g = pick(req);
        wait_ack(n);
        checks++;
        if (n !== 1 || ack !== (NREQ'(1) << g) || done !== (NREQ'(1) << g)) begin
            errors++; $display("FAIL dz_ackdone: got n=%0d ack=%b done=%b required 1 0100 0100", n, ack, done);
        end
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || dz !== 1'b1 || to !== 1'b0) begin
            errors++; $display("FAIL dz_result: got q=%h r=%h dz=%b to=%b required ffffffff 1234 1 0", q, r, dz, to);
        end
        req = 4'b0000;
        ptr = (g + 1) % NREQ;
        bad = (diven !== 1'b0 || busy !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (diven !== 1'b0 || busy !== 1'b0 || dz !== 1'b0 || done !== 0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dz_quiet: got %0d bad cycles required 0", bad); end
    endtask

    task automatic test_watchdog();
        int n, bad;
        never_valid = 1'b1;
        rand_ops(3);
        req = 4'b1000;
        wait_ack(n);
        checks++;
        if (ack !== 4'b1000) begin errors++; $display("FAIL wd_ack: got %b required 1000", ack); end
        req = 4'b0000;
        ptr = 0;
        wait_done(n);
        checks++;
        if (n !== TIMEOUT || done !== 4'b1000) begin
            errors++; $display("FAIL wd_latency: got n=%0d done=%b required %0d 1000", n, done, TIMEOUT);
        end
        checks++;
        if (to !== 1'b1 || q !== 32'd0 || r !== 32'd0 || dz !== 1'b0) begin
            errors++; $display("FAIL wd_result: got to=%b q=%h r=%h dz=%b required 1 0 0 0", to, q, r, dz);
        end
        repeat (3) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (done !== 0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wd_stray: got %0d cycles with done/busy required 0", bad); end
        never_valid = 1'b0;
    endtask

    task automatic test_coincide();
        int n;
        lat = TIMEOUT - 1;
        rand_ops(0);
        req = 4'b0001;
        wait_ack(n);
        exp_q.push_back(expect_entry(0, op_a[0], op_b[0]));
        req = 4'b0000;
        ptr = 1;
        wait_done(n);
        check_result("coincide", n, TIMEOUT);
    endtask

    task automatic test_reset_mid();
        int n, bad, g, cur_lat;
        lat = 34;
        rand_ops(1);
        req = 4'b0010;
        wait_ack(n);
        req = 4'b0000;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, done, q, r, dz, to, busy, diva, divb, diven, dbg} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got busy=%b a=%h b=%h q=%h required all 0", busy, diva, divb, q);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 0 || ack !== 0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_stale: got %0d cycles with ack/done required 0", bad); end
        rand_ops(1);
        rand_ops(3);
        req = 4'b1010;
        for (int t = 0; t < 2; t++) begin
            cur_lat = $urandom_range(2, 30);
            lat = cur_lat;
            g = pick(req);
            wait_ack(n);
            checks++;
            if (n !== 1 || ack !== (NREQ'(1) << g)) begin
                errors++; $display("FAIL midreset_grant%0d: got n=%0d ack=%b required 1 bit %0d", t, n, ack, g);
            end
            exp_q.push_back(expect_entry(g, op_a[g], op_b[g]));
            ptr = (g + 1) % NREQ;
            req[g] = 1'b0;
            wait_done(n);
            check_result("b2b", n, cur_lat + 1);
        end
    endtask

    initial begin
        req   = '0;
        a_bus = '0;
        b_bus = '0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_watchdog();
        test_coincide();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
